// File: rtl/frame_scheduler.sv
// Frame-synchronous game-logic sequencer: on each frame end it latches the buttons
// and starts NUM_TASKS tasks in order, each waiting for its own done level before the next.
module frame_scheduler #(
  parameter int NUM_TASKS         = 3,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic                 clk_rgb,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 de,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic [4:0]           buttons,
  input  logic [NUM_TASKS-1:0] task_done,
  input  logic                 clear_overrun,
  output logic [NUM_TASKS-1:0] task_start,
  output logic [4:0]           buttons_frame,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic [7:0]           skip_count,
  output logic                 overrun
);

  localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
  localparam logic [Y_WIDTH-1:0] LAST_LINE = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_TASKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_de_d;
  logic [NUM_TASKS-1:0] r_task_start;
  logic [4:0]           r_buttons_frame;
  logic                 r_busy;
  logic [15:0]          r_frame_count;
  logic [7:0]           r_skip_count;
  logic                 r_overrun;

  logic w_fe;
  logic w_fs;
  logic w_done;

  function automatic logic [NUM_TASKS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = NUM_TASKS'(1) << i;
  endfunction

  assign w_fe   = ce & r_de_d & ~de & (y == LAST_LINE);
  assign w_fs   = ce & ~r_de_d & de;
  assign w_done = task_done[r_idx];

  // Sequencer state, frame counters and sticky overrun; everything holds while ce is low.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_de_d          <= 1'b0;
      r_task_start    <= '0;
      r_buttons_frame <= 5'd0;
      r_busy          <= 1'b0;
      r_frame_count   <= 16'd0;
      r_skip_count    <= 8'd0;
      r_overrun       <= 1'b0;
    end else if (ce) begin
      r_de_d <= de;

      if (w_fe) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (r_busy && (r_skip_count != 8'hFF)) begin
          r_skip_count <= r_skip_count + 8'd1;
        end
      end

      if (w_fs && r_busy) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_fe) begin
            r_state         <= START;
            r_idx           <= '0;
            r_task_start    <= onehot(IDX_W'(0));
            r_buttons_frame <= buttons;
            r_busy          <= 1'b1;
          end
        end
        START: begin
          r_state      <= WAIT;
          r_task_start <= '0;
        end
        WAIT: begin
          if (w_done) begin
            if (r_idx == LAST_IDX) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= START;
              r_idx        <= r_idx + IDX_W'(1);
              r_task_start <= onehot(r_idx + IDX_W'(1));
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_idx        <= '0;
          r_task_start <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign task_start    = r_task_start;
  assign buttons_frame = r_buttons_frame;
  assign busy          = r_busy;
  assign frame_count   = r_frame_count;
  assign skip_count    = r_skip_count;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: a behavioural frame/task model predicts every cycle,
// task-start events are queued and popped by an independent monitor.
module tb_frame_scheduler;

  localparam int NT = 3;
  localparam int V  = 16;
  localparam int YW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          de = 1'b0;
  logic [YW-1:0] y = '0;
  logic [4:0]    buttons = '0;
  logic [NT-1:0] task_done = '0;
  logic          clear_overrun = 1'b0;
  logic [NT-1:0] task_start;
  logic [4:0]    buttons_frame;
  logic          busy;
  logic [15:0]   frame_count;
  logic [7:0]    skip_count;
  logic          overrun;

  int tests = 0;
  int fails = 0;

  // model state
  bit         m_active = 1'b0;
  bit         m_wait = 1'b0;
  int         m_task = 0;
  bit         m_de_prev = 1'b0;
  int         m_frames = 0;
  int         m_skips = 0;
  bit         m_over = 1'b0;
  logic [4:0] m_btn = '0;
  logic [7:0] exp_q[$];

  frame_scheduler #(.NUM_TASKS(NT), .VER_ACTIVE_PIXELS(V), .Y_WIDTH(YW)) dut (
    .clk_rgb(clk), .rst(rst), .ce(ce), .de(de), .y(y), .buttons(buttons),
    .task_done(task_done), .clear_overrun(clear_overrun), .task_start(task_start),
    .buttons_frame(buttons_frame), .busy(busy), .frame_count(frame_count),
    .skip_count(skip_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame end starts a run of NT tasks when none is running; each task
  // is announced for one enabled cycle, then finishes on the first enabled cycle its done bit is high.
  initial begin
    bit fe_b, fs_b, was_busy;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 0; m_wait = 0; m_task = 0; m_de_prev = 0;
        m_frames = 0; m_skips = 0; m_over = 0; m_btn = '0;
        exp_q.delete();
      end else if (ce) begin
        fe_b = m_de_prev && !de && (y == YW'(V - 1));
        fs_b = !m_de_prev && de;
        was_busy = m_active;
        if (fe_b) begin
          m_frames = (m_frames + 1) % 65536;
          if (was_busy && m_skips < 255) m_skips++;
        end
        if (fs_b && was_busy) m_over = 1;
        else if (clear_overrun) m_over = 0;
        if (!was_busy) begin
          if (fe_b) begin
            m_active = 1; m_task = 0; m_wait = 0; m_btn = buttons;
            exp_q.push_back({3'b001, buttons});
          end
        end else if (!m_wait) begin
          m_wait = 1;
        end else if (task_done[m_task]) begin
          if (m_task == NT - 1) begin
            m_active = 0;
          end else begin
            m_task++;
            m_wait = 0;
            exp_q.push_back({3'(1 << m_task), m_btn});
          end
        end
        m_de_prev = de;
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pop on each new task-start pulse.
  initial begin
    logic [NT-1:0] prev_ts, exp_ts;
    logic [7:0] e;
    prev_ts = '0;
    forever begin
      @(posedge clk);
      #1;
      exp_ts = (m_active && !m_wait) ? 3'(1 << m_task) : 3'b000;
      chk("cycle", {task_start, busy, overrun, frame_count, skip_count, buttons_frame},
          {exp_ts, m_active, m_over, 16'(m_frames), 8'(m_skips), m_btn});
      if (task_start != '0 && prev_ts == '0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected got=%b exp=none at %0t", task_start, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_start", {task_start, buttons_frame}, e);
        end
      end
      prev_ts = task_start;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; ce = 1; de = 0; y = '0; task_done = '0; clear_overrun = 0; buttons = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // de falls on the last active line; the fe edge is the next rising clock
  task automatic frame_end(input logic [4:0] b);
    @(negedge clk);
    ce = 1; y = YW'(V - 1); de = 1; buttons = b;
    @(negedge clk);
    de = 0;
  endtask

  initial begin
    logic [23:0] seq;
    int busy_cnt;
    bit saw;

    // reset values
    repeat (2) @(negedge clk);
    chk("reset_vals", {task_start, busy, overrun, frame_count, skip_count, buttons_frame}, 64'd0);
    rst = 0;

    // basic sequence with done tied high
    do_reset();
    task_done = 3'b111;
    frame_end(5'b00101);
    seq = '0; busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seq = {seq[20:0], task_start};
      if (busy) busy_cnt++;
    end
    chk("s1_pulses", seq, 24'b001_000_010_000_100_000_000_000);
    chk("s1_busy_cycles", busy_cnt, 6);
    chk("s1_frame_count", frame_count, 1);
    chk("s1_buttons", buttons_frame, 5'b00101);

    // task 1 held off with a stray task_done[2]
    do_reset();
    task_done = 3'b001;
    frame_end(5'b10000);
    repeat (4) @(negedge clk);
    saw = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      task_done = (i == 50) ? 3'b101 : 3'b001;
      if (task_start[2] || !busy) saw = 1;
    end
    chk("s2_no_advance", saw, 0);
    task_done = 3'b111;
    repeat (6) @(negedge clk);
    chk("s2_done_idle", busy, 0);

    // stuck task 0, active video start, second frame end
    do_reset();
    task_done = 3'b000;
    frame_end(5'b01010);
    @(negedge clk);
    y = '0; de = 1;
    @(negedge clk);
    chk("s3_overrun_set", overrun, 1);
    frame_end(5'b11111);
    @(negedge clk);
    chk("s3_skip", skip_count, 1);
    chk("s3_frames", frame_count, 2);
    chk("s3_buttons_hold", buttons_frame, 5'b01010);
    chk("s3_still_busy", {busy, overrun}, 2'b11);

    // clear, then clear coincident with a busy frame start
    @(negedge clk);
    clear_overrun = 1;
    @(negedge clk);
    clear_overrun = 0;
    chk("s4_cleared", overrun, 0);
    @(negedge clk);
    y = '0; de = 1; clear_overrun = 1;
    @(negedge clk);
    clear_overrun = 0; de = 0;
    chk("s4_set_wins", overrun, 1);

    // clock-enable stall during START
    do_reset();
    task_done = 3'b000;
    frame_end(5'b00011);
    @(negedge clk);
    ce = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      de = ~de; y = YW'(V - 1);
      chk("s5_start_held", task_start, 3'b001);
    end
    chk("s5_counters_frozen", {busy, overrun, frame_count, skip_count}, {1'b1, 1'b0, 16'd1, 8'd0});
    ce = 1;
    @(negedge clk);
    chk("s5_to_wait", task_start, 3'b000);

    // reset in WAIT with idx=1
    do_reset();
    task_done = 3'b001;
    frame_end(5'b00111);
    repeat (4) @(negedge clk);
    chk("s6_in_wait", {task_start, busy}, 4'b0001);
    rst = 1;
    #1;
    chk("s6_async_zero", {task_start, busy, overrun, frame_count, skip_count, buttons_frame}, 64'd0);
    task_done = 3'b111;
    repeat (2) @(negedge clk);
    rst = 0;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (task_start != '0) saw = 1;
    end
    chk("s6_no_start", saw, 0);
    frame_end(5'b00000);
    @(negedge clk);
    chk("s6_fresh_start", task_start, 3'b001);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 799) == 0);
      ce = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) de = ~de;
      y = ($urandom_range(0, 1) == 1) ? YW'(V - 1) : YW'($urandom_range(0, 15));
      buttons = 5'($urandom);
      task_done = 3'($urandom) & 3'($urandom);
      clear_overrun = ($urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    rst = 0; ce = 1; de = 0; task_done = 3'b111; clear_overrun = 0;
    repeat (10) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
